accel_iter_alu: RTL
===================

# accel_iter_alu

Multi-cycle arithmetic engine that sits directly downstream of the accelerator peripheral's operand/opcode registers (A, B, opcode) and produces the 16-bit value the peripheral exposes as its result low/high bytes. Single-cycle logic ops complete in one cycle. MUL and DIV run as 8-iteration shift-add and restoring-division sequences, so no wide combinational multiplier or divider sits in the register read path. A start/busy/done handshake lets the peripheral launch an operation on an opcode write and poll completion.

## Interface
Parameters:
- none (operand width fixed at 8, result width 16)

Ports:
- clk  in  1  project clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- a  in  8  operand A; captured on accepted start
- b  in  8  operand B; captured on accepted start
- opcode  in  4  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7–15 unsupported
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when result is valid
- result  out  16  registered result; held until the next accepted start
- err  out  1  registered; set for divide-by-zero or unsupported opcode; held with result

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture a, b, opcode; clear err.
  - ADD/SUB/AND/OR/XOR/unsupported: compute result, go to DONE.
  - MUL/DIV: load working registers, set iteration counter to 0, go to RUN.
- RUN: perform one iteration per cycle, counter 0..7. After iteration 7, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; no queuing.
- Arithmetic rules (operands zero-extended to 16 bits):
  - ADD = a+b.
  - SUB = (a−b) mod 2^16, so 5−7 = 0xFFFE.
  - AND/OR/XOR produce the 8-bit value in result[7:0], with result[15:8] = 0.
  - MUL: unsigned 8×8 → 16-bit product via LSB-first shift-add.
  - DIV: restoring division; result = {remainder[7:0], quotient[7:0]}.
- DIV with b=0: still takes 8 iterations; result = {a, 8'hFF}, err=1.
- Unsupported opcode: result = 0x0000, err=1.
- Operand inputs may change after start is accepted; the captured copies are used.

## Timing
- Reset values: busy=0, done=0, result=0x0000, err=0, state=IDLE, counter=0.
- Reset asserted mid-RUN or in DONE: the next edge aborts the operation and applies reset values. done does not pulse for the aborted operation.
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
  - Single-cycle ops: result, err and done valid in cycle 1; busy=1 in cycle 1 only.
  - MUL/DIV: RUN spans cycles 1–8; done=1 in cycle 9; busy=1 in cycles 1–9.
- result changes only on the edge that enters DONE; it is stable while done=1 and afterwards. Intermediate values never appear on result.
- Back-to-back: start=1 in the cycle after done (IDLE) is accepted. Minimum issue interval is 2 cycles for single-cycle ops and 10 cycles for MUL/DIV.
- start and rst in the same cycle: rst wins.

## Configuration
- ACCEL_ITER_DIV_EN:
  - Defined: the DIV datapath is built and opcode 3 behaves as above.
  - Undefined: no divider logic is built. Opcode 3 is treated as unsupported: single-cycle completion, result=0x0000, err=1.
  - MUL and all other ops are unaffected either way.

## Test plan
- Reset, then ADD a=0xFF b=0x01 → done in cycle 1, result=0x0100, err=0, busy high for one cycle.
- SUB a=0x05 b=0x07 → result=0xFFFE in cycle 1; then XOR a=0xF0 b=0x3C → result=0x00CC.
- MUL a=0xFF b=0xFF → busy cycles 1–9, done only in cycle 9, result=0xFE01. Change a/b during RUN → result unchanged.
- DIV a=200 b=7 → result=0x041C in cycle 9, err=0. DIV a=0x2A b=0 → result=0x2AFF, err=1. With ACCEL_ITER_DIV_EN undefined, DIV a=200 b=7 → cycle 1, result=0x0000, err=1.
- Start MUL, re-pulse start with ADD in cycle 4 → ignored, MUL result delivered in cycle 9; ADD issued in cycle 10 → accepted, done in cycle 11.
- Start MUL, assert rst in cycle 5 → cycle 6 shows busy=0, done=0, result=0x0000, err=0, and no done pulse follows. Opcode 9 → result=0x0000, err=1 in cycle 1.

Source files
------------

// File: rtl/accel_iter_alu.sv
// accel_iter_alu: start/busy/done arithmetic engine; logic ops finish in one cycle,
// MUL/DIV iterate 8 cycles. Optional divider built only when ACCEL_ITER_DIV_EN is defined.
module accel_iter_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [3:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6
  } op_t;

  state_t      state, state_nxt;
  logic [2:0]  iter;
  logic        last_iter;
  logic        op_iter;
  logic [15:0] sc_result;
  logic        sc_err;

  logic [15:0] mul_acc, mul_mcand, mul_acc_nxt;
  logic [7:0]  mul_mplier;

  assign last_iter = (iter == 3'd7);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    op_iter = (opcode == OP_MUL);
`ifdef ACCEL_ITER_DIV_EN
    if (opcode == OP_DIV) op_iter = 1'b1;
`endif
  end

  always_comb begin
    sc_result = '0;
    sc_err    = 1'b0;
    case (opcode)
      OP_ADD:  sc_result = {8'h00, a} + {8'h00, b};
      OP_SUB:  sc_result = {8'h00, a} - {8'h00, b};
      OP_AND:  sc_result = {8'h00, a & b};
      OP_OR:   sc_result = {8'h00, a | b};
      OP_XOR:  sc_result = {8'h00, a ^ b};
      OP_MUL:  sc_err = 1'b0;
`ifdef ACCEL_ITER_DIV_EN
      OP_DIV:  sc_err = 1'b0;
`endif
      default: sc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = op_iter ? S_RUN : S_DONE;
      S_RUN:   if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mul_acc_nxt = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
  end

`ifdef ACCEL_ITER_DIV_EN
  logic       is_div;
  logic [7:0] div_rem, div_quot, div_dsr;
  logic [7:0] div_rem_nxt, div_quot_nxt;
  logic [8:0] div_shift;
  logic       div_ge;

  // Partial remainder stays below the divisor, so an 8-bit difference is exact.
  // With a zero divisor every step subtracts nothing, yielding {a, 8'hFF} naturally.
  always_comb begin
    div_shift = {div_rem, div_quot[7]};
    div_ge    = (div_shift >= {1'b0, div_dsr});
    if (div_ge) begin
      div_rem_nxt  = div_shift[7:0] - div_dsr;
      div_quot_nxt = {div_quot[6:0], 1'b1};
    end else begin
      div_rem_nxt  = div_shift[7:0];
      div_quot_nxt = {div_quot[6:0], 1'b0};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      iter       <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      result     <= '0;
      err        <= 1'b0;
`ifdef ACCEL_ITER_DIV_EN
      is_div     <= 1'b0;
      div_rem    <= '0;
      div_quot   <= '0;
      div_dsr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            iter       <= '0;
            err        <= sc_err;
            mul_acc    <= '0;
            mul_mcand  <= {8'h00, a};
            mul_mplier <= b;
            if (!op_iter) result <= sc_result;
`ifdef ACCEL_ITER_DIV_EN
            is_div     <= (opcode == OP_DIV);
            div_rem    <= '0;
            div_quot   <= a;
            div_dsr    <= b;
`endif
          end
        end
        S_RUN: begin
          iter       <= iter + 3'd1;
          mul_acc    <= mul_acc_nxt;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
`ifdef ACCEL_ITER_DIV_EN
          div_rem    <= div_rem_nxt;
          div_quot   <= div_quot_nxt;
`endif
          if (last_iter) begin
            result <= mul_acc_nxt;
`ifdef ACCEL_ITER_DIV_EN
            if (is_div) begin
              result <= {div_rem_nxt, div_quot_nxt};
              err    <= (div_dsr == 8'h00);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
